// File: rtl/triangle_pkg.sv
// Shared definitions for the triangle-wave tracker: FSM state encoding and
// the two legal step values between consecutive samples.
package triangle_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_SEEDED  = 2'd1,
      ST_RISING  = 2'd2,
      ST_FALLING = 2'd3
   } state_t;

   // Legal steps; cast to the sample width at the point of use so that
   // DELTA_DN becomes all-ones (i.e. -1 modulo 2^WIDTH).
   localparam int DELTA_UP = 1;
   localparam int DELTA_DN = -1;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and saturation at all-ones.
// Clear takes priority over increment.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Count register: clear wins, otherwise increment until all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/triangle_tracker.sv
// Tracks a triangle waveform produced by an up/down counter. Detects the
// turnarounds, measures the peak-to-peak period, and flags any sample that
// breaks the +1/-1 step sequence.
//
// Input handshake: ena acts as a valid strobe with no backpressure. A sample
// is consumed on every rising edge where ena=1; cycles with ena=0 leave all
// tracking state untouched and produce no pulses. Responses are registered
// and visible one cycle after the consuming edge.
module triangle_tracker
   import triangle_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int ERRW  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [WIDTH-1:0] sample,
   input  logic             clr,
   output logic             dir_up,
   output logic             peak,
   output logic             valley,
   output logic [WIDTH:0]   period,
   output logic             period_valid,
   output logic             step_err,
   output logic             locked,
   output logic [ERRW-1:0]  err_cnt,
   output state_t           dbg_state
);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] delta;
   logic [WIDTH:0]   acc;
   logic [WIDTH:0]   period_load;
   logic             is_up;
   logic             is_dn;
   logic             is_hold;
   logic             prev_max;
   logic             prev_min;
   logic             ev_peak;
   logic             ev_valley;
   logic             ev_err;
   logic             ev_entry;
   logic             peak_seen;

   assign delta       = sample - prev;
   assign is_up       = (delta == WIDTH'(DELTA_UP));
   assign is_dn       = (delta == WIDTH'(DELTA_DN));
   assign is_hold     = (delta == '0);
   assign prev_max    = (prev == '1);
   assign prev_min    = (prev == '0);
   // Peak sample itself is the final count of the period, so add one.
   assign period_load = (acc == '1) ? acc : acc + (WIDTH+1)'(1);
   assign dbg_state   = state;

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and event decode; all events are qualified by ena.
   always_comb begin
      state_nxt = state;
      ev_peak   = 1'b0;
      ev_valley = 1'b0;
      ev_err    = 1'b0;
      ev_entry  = 1'b0;
      if (ena) begin
         case (state)
            ST_EMPTY: begin
               state_nxt = ST_SEEDED;
            end
            ST_SEEDED: begin
               if (is_up) begin
                  state_nxt = ST_RISING;
                  ev_entry  = 1'b1;
               end else if (is_dn) begin
                  state_nxt = ST_FALLING;
                  ev_entry  = 1'b1;
               end else if (!is_hold) begin
                  ev_err = 1'b1;
               end
            end
            ST_RISING: begin
               if (is_dn && prev_max) begin
                  ev_peak   = 1'b1;
                  state_nxt = ST_FALLING;
               end else if (!is_hold && !(is_up && !prev_max)) begin
                  // Includes the all-ones to zero wrap.
                  ev_err    = 1'b1;
                  state_nxt = ST_SEEDED;
               end
            end
            ST_FALLING: begin
               if (is_up && prev_min) begin
                  ev_valley = 1'b1;
                  state_nxt = ST_RISING;
               end else if (!is_hold && !(is_dn && !prev_min)) begin
                  // Includes the zero to all-ones wrap.
                  ev_err    = 1'b1;
                  state_nxt = ST_SEEDED;
               end
            end
            default: begin
               state_nxt = ST_EMPTY;
            end
         endcase
      end
   end

   // Registered outputs, sample history and lock qualification.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev         <= '0;
         dir_up       <= 1'b0;
         peak         <= 1'b0;
         valley       <= 1'b0;
         step_err     <= 1'b0;
         period       <= '0;
         period_valid <= 1'b0;
         locked       <= 1'b0;
         peak_seen    <= 1'b0;
      end else begin
         peak     <= ev_peak;
         valley   <= ev_valley;
         step_err <= ev_err;
         dir_up   <= (state_nxt == ST_RISING);
         if (ena) begin
            prev <= sample;
         end
         if (ev_peak) begin
            period <= period_load;
         end
         // A lock needs two peaks since the last (re)entry into tracking.
         if (ev_entry || ev_err) begin
            peak_seen <= 1'b0;
         end else if (ev_peak) begin
            peak_seen <= 1'b1;
         end
         if (clr || ev_err) begin
            period_valid <= 1'b0;
            locked       <= 1'b0;
         end else if (ev_peak && peak_seen) begin
            period_valid <= 1'b1;
            locked       <= 1'b1;
         end
      end
   end

   // Period accumulator: restarts on a peak or a sequence break.
   sat_counter #(
      .W (WIDTH + 1)
   ) u_period_acc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (ev_peak | ev_err),
      .inc   (ena),
      .count (acc)
   );

   // Step error counter: clr overrides a coincident error.
   sat_counter #(
      .W (ERRW)
   ) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (ev_err),
      .count (err_cnt)
   );

endmodule

// File: doc/triangle_tracker.md
TRIANGLE_TRACKER -- requirements
Module: triangle_tracker

Interface
REQ-001 Parameter WIDTH, default 16: sample width in bits.
REQ-002 Parameter ERRW, default 8: width of the error counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ena  input  1  sample strobe; sample is consumed only on cycles with ena=1.
REQ-006 sample  input  WIDTH  triangle-wave value from the up/down triangle counter.
REQ-007 clr  input  1  synchronous clear of err_cnt, period_valid and locked.
REQ-008 dir_up  output  1  1 = tracked waveform is rising.
REQ-009 peak  output  1  one-cycle pulse at the top turnaround.
REQ-010 valley  output  1  one-cycle pulse at the bottom turnaround.
REQ-011 period  output  WIDTH+1  sample count between the last two peaks.
REQ-012 period_valid  output  1  period holds a complete measurement.
REQ-013 step_err  output  1  one-cycle pulse when a sample breaks the triangle sequence.
REQ-014 locked  output  1  a full error-free peak-to-peak cycle has been seen.
REQ-015 err_cnt  output  ERRW  count of step errors, saturating at all-ones.

Function
REQ-016 Define delta = sample - prev, modulo 2^WIDTH, where prev is the last accepted sample.
REQ-017 Every ena=1 sample updates prev; ena=0 cycles change no state, and all pulses are 0 on those cycles.
REQ-018 FSM states are EMPTY, SEEDED, RISING and FALLING.
REQ-019 EMPTY: capture the sample and go to SEEDED; no pulses.
REQ-020 SEEDED: on delta=+1 go to RISING; on delta=-1 go to FALLING; any other nonzero delta pulses step_err and stays in SEEDED.
REQ-021 RISING, delta=+1 with prev not all-ones: stay in RISING.
REQ-022 RISING, delta=-1 with prev all-ones: pulse peak and go to FALLING.
REQ-023 FALLING, delta=-1 with prev not zero: stay in FALLING.
REQ-024 FALLING, delta=+1 with prev zero: pulse valley and go to RISING.
REQ-025 Wrap-around steps are errors: all-ones to zero while RISING, and zero to all-ones while FALLING.
REQ-026 Any other nonzero delta in RISING or FALLING pulses step_err, goes to SEEDED, clears locked and period_valid, and zeroes the period accumulator.
REQ-027 delta=0 is a hold: no state change and no error.
REQ-028 dir_up = 1 only in RISING.
REQ-029 Period accumulator: counts accepted samples after a peak, saturating at all-ones (WIDTH+1 bits).
REQ-030 On each peak, the accumulator value+1 is loaded into period and the accumulator restarts at 0.
REQ-031 period_valid and locked set on the second peak after entry to RISING/FALLING, provided no error occurred in between.
REQ-032 Full-scale period = 2*(2^WIDTH-1).
REQ-033 err_cnt increments on each step_err and saturates at all-ones.
REQ-034 clr has priority over a simultaneous step_err increment (err_cnt reads 0 afterwards); clr does not change FSM state.
REQ-035 All outputs are registered: response appears one cycle after the ena sample edge.

Reset
REQ-036 rst_n=0 immediately forces: state EMPTY, prev 0, dir_up 0, peak/valley/step_err 0, period 0, period_valid 0, locked 0, err_cnt 0, accumulator 0.
REQ-037 Reset asserted mid-waveform discards all history; the first sample after release is treated as a seed.

Structure
REQ-038 Package triangle_pkg holds the FSM state encoding and the DELTA_UP/DELTA_DN constants.
REQ-039 One sub-module, sat_counter (parameterised width, inc, clear, saturate), is instantiated for both the period accumulator and err_cnt.
REQ-040 Target size is 120-400 lines of RTL.

Verification (WIDTH=4)
REQ-041 Stimulus 0,1,...,15,14,...,0,1,...,15,14 with ena=1 every cycle -> valley once, peaks at each 15->14 step, second peak gives period=30, period_valid=1, locked=1.
REQ-042 Triangle with ena toggling 1/0 -> identical pulses and period=30; no pulses on ena=0 cycles.
REQ-043 Samples 5,6,9 -> step_err pulse on the 9, state SEEDED, locked=0, err_cnt=1.
REQ-044 Samples 14,15,0 -> step_err (wrap treated as error), no peak.
REQ-045 Force 300 errors -> err_cnt=255 (ERRW=8); clr coincident with step_err -> err_cnt=0.
REQ-046 rst_n low while locked mid-rise at sample 7 -> all outputs 0 immediately; after release, samples 7,8 resume RISING with no step_err.
